shift_reg_univ: RTL and testbench



---
 rtl/shift_reg_univ_if.sv | 25 ++
 rtl/shift_reg_univ.sv | 94 +++++++++
 tb/tb_shift_reg_univ.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/shift_reg_univ_if.sv
// Bus bundle for the universal shift register: control/data in, register view and
// burst handshake out.
interface shift_reg_univ_if #(
  parameter int WIDTH = 8
);
  logic [2:0]       mode;
  logic             s_in_r;
  logic             s_in_l;
  logic [WIDTH-1:0] p_in;
  logic [WIDTH-1:0] q;
  logic             s_out_r;
  logic             s_out_l;
  logic             busy;
  logic             done;

  modport master (
    output mode, s_in_r, s_in_l, p_in,
    input  q, s_out_r, s_out_l, busy, done
  );

  modport slave (
    input  mode, s_in_r, s_in_l, p_in,
    output q, s_out_r, s_out_l, busy, done
  );
endinterface

// File: rtl/shift_reg_univ.sv
// Universal shift register (hold/shift/rotate/load) with an LSB-first burst serializer
// that shifts a loaded word out over WIDTH edges under a busy/done handshake.
module shift_reg_univ #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  shift_reg_univ_if.slave      bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHR   = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_ROR   = 3'b011,
    MODE_ROL   = 3'b100,
    MODE_LOAD  = 3'b101,
    MODE_BURST = 3'b110,
    MODE_RSVD  = 3'b111
  } mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  mode_e            mode;

  assign mode = mode_e'(bus.mode);

  always_comb begin
    // NOTE: every path gets a value from this default, so no latch is inferred.
    q_d = q_q;
    if (state_q == BURST) begin
      q_d = {bus.s_in_r, q_q[WIDTH-1:1]};
    end else begin
      case (mode)
        MODE_SHR:              q_d = {bus.s_in_r, q_q[WIDTH-1:1]};
        MODE_SHL:              q_d = {q_q[WIDTH-2:0], bus.s_in_l};
        MODE_ROR:              q_d = {q_q[0], q_q[WIDTH-1:1]};
        MODE_ROL:              q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        MODE_LOAD, MODE_BURST: q_d = bus.p_in;
        default:               q_d = q_q;
      endcase
    end
  end

  // Reset wins over everything, so an aborted burst never raises done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      q_q    <= q_d;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mode == MODE_BURST) begin
            state_q <= BURST;
            cnt_q   <= CW'(WIDTH);
            busy_q  <= 1'b1;
          end
        end
        BURST: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.q       = q_q;
  assign bus.s_out_r = q_q[0];
  assign bus.s_out_l = q_q[WIDTH-1];
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Bench for shift_reg_univ: WIDTH=2, 8 and 32 instances driven in lockstep and compared
// every edge against a behavioural model, plus directed vectors and burst sequences.
module tb_shift_reg_univ;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  shift_reg_univ_if #(.WIDTH(2))  b2 ();
  shift_reg_univ_if #(.WIDTH(8))  b8 ();
  shift_reg_univ_if #(.WIDTH(32)) b32 ();

  shift_reg_univ #(.WIDTH(2))  u2  (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
  shift_reg_univ #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
  shift_reg_univ #(.WIDTH(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: register value plus number of burst shifts still owed.
  typedef struct {
    int          w;
    logic [31:0] q;
    int          left;
    bit          done;
  } mdl_t;

  mdl_t m[3];

  bit          cur_rst_n;
  logic [2:0]  cur_mode;
  bit          cur_sr, cur_sl;
  logic [31:0] cur_p;

  function automatic mdl_t mstep(mdl_t s, bit r, logic [2:0] md, bit sr, bit sl,
                                 logic [31:0] p);
    mdl_t n;
    longint unsigned mask, v, top;
    n    = s;
    mask = (64'd1 << s.w) - 64'd1;
    v    = 64'(s.q);
    top  = 64'd1 << (s.w - 1);
    if (!r) begin
      n.q = '0; n.left = 0; n.done = 1'b0;
      return n;
    end
    n.done = 1'b0;
    if (s.left > 0) begin
      v      = (v >> 1) | (sr ? top : 64'd0);
      n.left = s.left - 1;
      n.done = (n.left == 0);
    end else begin
      case (md)
        3'd1: v = (v >> 1) | (sr ? top : 64'd0);
        3'd2: v = (v << 1) | 64'(sl);
        3'd3: v = (v >> 1) | (v[0] ? top : 64'd0);
        3'd4: v = (v << 1) | (v >> (s.w - 1));
        3'd5: v = 64'(p);
        3'd6: begin v = 64'(p); n.left = s.w; end
        default: ;
      endcase
    end
    n.q = 32'(v & mask);
    return n;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(bit r, logic [2:0] md, bit sr, bit sl, logic [31:0] p);
    rst_n     = r;
    cur_rst_n = r; cur_mode = md; cur_sr = sr; cur_sl = sl; cur_p = p;
    b2.mode  = md; b2.s_in_r  = sr; b2.s_in_l  = sl; b2.p_in  = p[1:0];
    b8.mode  = md; b8.s_in_r  = sr; b8.s_in_l  = sl; b8.p_in  = p[7:0];
    b32.mode = md; b32.s_in_r = sr; b32.s_in_l = sl; b32.p_in = p;
  endtask

  task automatic compare_all();
    check("q_w2",    32'(b2.q),        m[0].q);
    check("sor_w2",  32'(b2.s_out_r),  32'(m[0].q[0]));
    check("sol_w2",  32'(b2.s_out_l),  32'(m[0].q[1]));
    check("busy_w2", 32'(b2.busy),     32'(m[0].left > 0));
    check("done_w2", 32'(b2.done),     32'(m[0].done));
    check("q_w8",    32'(b8.q),        m[1].q);
    check("sor_w8",  32'(b8.s_out_r),  32'(m[1].q[0]));
    check("sol_w8",  32'(b8.s_out_l),  32'(m[1].q[7]));
    check("busy_w8", 32'(b8.busy),     32'(m[1].left > 0));
    check("done_w8", 32'(b8.done),     32'(m[1].done));
    check("q_w32",   b32.q,            m[2].q);
    check("sor_w32", 32'(b32.s_out_r), 32'(m[2].q[0]));
    check("sol_w32", 32'(b32.s_out_l), 32'(m[2].q[31]));
    check("busy_w32",32'(b32.busy),    32'(m[2].left > 0));
    check("done_w32",32'(b32.done),    32'(m[2].done));
  endtask

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 3; i++) m[i] = mstep(m[i], cur_rst_n, cur_mode, cur_sr, cur_sl, cur_p);
    #1;
    compare_all();
  endtask

  typedef struct {
    bit         rst_n;
    logic [2:0] mode;
    bit         sr, sl;
    logic [7:0] p;
    logic [7:0] q;
    bit         busy, done;
  } vec_t;

  vec_t vt[19];

  initial begin
    logic [7:0] burst_word;
    int edges, dones;

    m[0] = '{w: 2,  q: '0, left: 0, done: 1'b0};
    m[1] = '{w: 8,  q: '0, left: 0, done: 1'b0};
    m[2] = '{w: 32, q: '0, left: 0, done: 1'b0};

    vt[0]  = '{1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 3'd5, 1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 3'd5, 1'b0, 1'b0, 8'hA5, 8'hA5, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 3'd0, 1'b1, 1'b1, 8'h3C, 8'hA5, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 3'd0, 1'b0, 1'b1, 8'h3C, 8'hA5, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 3'd0, 1'b1, 1'b0, 8'h3C, 8'hA5, 1'b0, 1'b0};
    vt[6]  = '{1'b1, 3'd5, 1'b0, 1'b0, 8'h81, 8'h81, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 3'd1, 1'b1, 1'b0, 8'h00, 8'hC0, 1'b0, 1'b0};
    vt[8]  = '{1'b1, 3'd5, 1'b0, 1'b0, 8'h81, 8'h81, 1'b0, 1'b0};
    vt[9]  = '{1'b1, 3'd2, 1'b1, 1'b0, 8'h00, 8'h02, 1'b0, 1'b0};
    vt[10] = '{1'b1, 3'd5, 1'b0, 1'b0, 8'h81, 8'h81, 1'b0, 1'b0};
    vt[11] = '{1'b1, 3'd3, 1'b0, 1'b0, 8'h00, 8'hC0, 1'b0, 1'b0};
    vt[12] = '{1'b1, 3'd5, 1'b0, 1'b0, 8'h81, 8'h81, 1'b0, 1'b0};
    vt[13] = '{1'b1, 3'd4, 1'b0, 1'b0, 8'h00, 8'h03, 1'b0, 1'b0};
    vt[14] = '{1'b1, 3'd5, 1'b0, 1'b0, 8'h5A, 8'h5A, 1'b0, 1'b0};
    vt[15] = '{1'b1, 3'd7, 1'b1, 1'b1, 8'hFF, 8'h5A, 1'b0, 1'b0};
    vt[16] = '{1'b1, 3'd7, 1'b0, 1'b1, 8'h00, 8'h5A, 1'b0, 1'b0};
    vt[17] = '{1'b1, 3'd7, 1'b1, 1'b0, 8'hC3, 8'h5A, 1'b0, 1'b0};
    vt[18] = '{1'b1, 3'd7, 1'b1, 1'b1, 8'h11, 8'h5A, 1'b0, 1'b0};

    drive(1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 19; i++) begin
      drive(vt[i].rst_n, vt[i].mode, vt[i].sr, vt[i].sl, {24'h0, vt[i].p});
      step();
      check("vec_q",    32'(b8.q),    32'(vt[i].q));
      check("vec_busy", 32'(b8.busy), 32'(vt[i].busy));
      check("vec_done", 32'(b8.done), 32'(vt[i].done));
    end

    // LOAD then SHR at every width.
    drive(1'b1, 3'd5, 1'b0, 1'b0, 32'hDEADBEEF);
    step();
    check("load_w2",  32'(b2.q), 32'h3);
    check("load_w32", b32.q,     32'hDEADBEEF);
    drive(1'b1, 3'd1, 1'b0, 1'b0, 32'h0);
    step();
    check("shr_w2",  32'(b2.q), 32'h1);
    check("shr_w8",  32'(b8.q), 32'h77);
    check("shr_w32", b32.q,     32'h6F56DF77);

    // Burst of 0x96 with mode/p_in scrambled during the shift.
    burst_word = 8'h96;
    drive(1'b1, 3'd6, 1'b0, 1'b0, 32'h96);
    step();
    check("burst_busy0", 32'(b8.busy),    32'h1);
    check("burst_sor0",  32'(b8.s_out_r), 32'(burst_word[0]));
    for (int k = 1; k < 8; k++) begin
      drive(1'b1, 3'($urandom_range(0, 7)), 1'b0, 1'($urandom), $urandom);
      step();
      check("burst_busy", 32'(b8.busy),    32'h1);
      check("burst_sor",  32'(b8.s_out_r), 32'(burst_word[k]));
    end
    drive(1'b1, 3'd5, 1'b0, 1'b0, 32'hFFFF_FFFF);
    step();
    check("burst_end_busy", 32'(b8.busy), 32'h0);
    check("burst_end_done", 32'(b8.done), 32'h1);
    check("burst_end_q",    32'(b8.q),    32'h0);

    // Back-to-back: restart in the done cycle; next done must come 9 edges later.
    drive(1'b1, 3'd6, 1'b1, 1'b0, 32'hFF);
    step();
    check("b2b_busy", 32'(b8.busy), 32'h1);
    edges = 1;
    dones = 0;
    drive(1'b1, 3'd0, 1'b1, 1'b0, 32'h0);
    while (edges < 20 && !b8.done) begin
      step();
      edges++;
    end
    if (b8.done) dones++;
    check("b2b_gap",   32'(edges), 32'd9);
    check("b2b_q",     32'(b8.q),  32'hFF);
    step();
    if (b8.done) dones++;
    check("b2b_dones", 32'(dones), 32'd1);

    // Reset after three burst shifts aborts without a done pulse.
    drive(1'b1, 3'd6, 1'b1, 1'b0, 32'h3C);
    step();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 3'd0, 1'b1, 1'b0, 32'h0);
      step();
    end
    drive(1'b0, 3'd6, 1'b1, 1'b0, 32'h3C);
    step();
    check("abort_q",    32'(b8.q),    32'h0);
    check("abort_busy", 32'(b8.busy), 32'h0);
    check("abort_done", 32'(b8.done), 32'h0);
    dones = 0;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 3'd0, 1'b0, 1'b0, 32'h0);
      step();
      if (b8.done) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);

    // Random stimulus against the model.
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 59) != 0), 3'($urandom_range(0, 7)), 1'($urandom),
            1'($urandom), $urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
